// File: rtl/wb_grf.sv
// wb_grf: write-back stage and general register file of the five-stage pipeline.
// Selects and extends the write-back value from the M/W register contents, commits
// it to the 32x32 register file, serves two D-stage read ports with write-first
// bypass, exports the W-stage forwarding value and counts retired instructions.
// Optional feature: define GRF_TRACE_EN to print one trace line per committed write.
module wb_grf #(
    parameter logic [31:0] LINK_OFFSET = 32'd8,
    parameter int          NREGS       = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] W_ReadData,
    input  logic [31:0] W_ALUData,
    input  logic [4:0]  W_TargetReg,
    input  logic [31:0] W_Ins,
    input  logic [31:0] W_PCAddr,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_reg,
    output logic [31:0] instret
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_LHU     = 6'b100101;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    logic [31:0] regs [0:NREGS-1];
    logic [31:0] instret_q;
    logic        we;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [1:0]  lane;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Only the opcode and funct fields of the instruction matter here.
    logic unused_ins_bits;
    assign unused_ins_bits = &{1'b0, W_Ins[25:6]};

    assign opcode = W_Ins[31:26];
    assign funct  = W_Ins[5:0];
    assign lane   = W_ALUData[1:0];

    // Write enable: a real destination and no reset in this cycle (reset wins).
    always_comb begin
        we     = (W_TargetReg != 5'd0) && !reset;
        wb_reg = we ? W_TargetReg : 5'd0;
    end

    // Extract the addressed halfword and byte from the little-endian memory word.
    always_comb begin
        half_sel = lane[1] ? W_ReadData[31:16] : W_ReadData[15:0];
        case (lane)
            2'd0:    byte_sel = W_ReadData[7:0];
            2'd1:    byte_sel = W_ReadData[15:8];
            2'd2:    byte_sel = W_ReadData[23:16];
            default: byte_sel = W_ReadData[31:24];
        endcase
    end

    // Select and extend the write-back value by instruction type.
    always_comb begin
        // NOTE: assign a default first so every path drives wb_data and no latch is inferred.
        wb_data = W_ALUData;
        case (opcode)
            OP_LW:      wb_data = W_ReadData;
            OP_LH:      wb_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:     wb_data = {16'h0000, half_sel};
            OP_LB:      wb_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:     wb_data = {24'h000000, byte_sel};
            OP_JAL:     wb_data = W_PCAddr + LINK_OFFSET;
            OP_SPECIAL: if (funct == FN_JALR) wb_data = W_PCAddr + LINK_OFFSET;
            default:    wb_data = W_ALUData;
        endcase
    end

    // Register file: synchronous clear, then commit the write-back value.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the architectural state must read zero after reset, so the whole
            // array is cleared; this keeps it in flops rather than a RAM macro.
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (we) begin
            // NOTE: non-blocking assignment so every flop samples pre-edge values.
            regs[W_TargetReg] <= wb_data;
        end
    end

    // Read port 1: zero register, then write-first bypass, then storage.
    always_comb begin
        if (rs_addr == 5'd0)
            rs_data = 32'h0;
        else if (rs_addr == wb_reg)
            rs_data = wb_data;
        else
            rs_data = regs[rs_addr];
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        if (rt_addr == 5'd0)
            rt_data = 32'h0;
        else if (rt_addr == wb_reg)
            rt_data = wb_data;
        else
            rt_data = regs[rt_addr];
    end

    // Retired-instruction counter: counts every non-bubble, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset)
            instret_q <= 32'h0;
        else if (W_Ins != 32'h0)
            instret_q <= instret_q + 32'd1;
    end

    assign instret = instret_q;

`ifdef GRF_TRACE_EN
    // Trace every committed register write.
    always_ff @(posedge clk) begin
        if (we)
            $display("%d@%h: $%d <= %h", $time, W_PCAddr, W_TargetReg, wb_data);
    end
`else
`endif

endmodule

// File: tb/tb_wb_grf.sv
// tb_wb_grf: self-checking bench for wb_grf. Directed cases for the value
// extensions, link wrap, reset priority and counter wrap, followed by random
// traffic compared against a behavioural register-file model.
module tb_wb_grf;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] W_ReadData;
    logic [31:0] W_ALUData;
    logic [4:0]  W_TargetReg;
    logic [31:0] W_Ins;
    logic [31:0] W_PCAddr;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data;
    logic [4:0]  wb_reg;
    logic [31:0] instret;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_instret;

    wb_grf dut (
        .clk         (clk),
        .reset       (reset),
        .W_ReadData  (W_ReadData),
        .W_ALUData   (W_ALUData),
        .W_TargetReg (W_TargetReg),
        .W_Ins       (W_Ins),
        .W_PCAddr    (W_PCAddr),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .wb_data     (wb_data),
        .wb_reg      (wb_reg),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Value the instruction should write back, from the ISA rules.
    function automatic logic [31:0] model_wb(input logic [31:0] ins, input logic [31:0] rd,
                                             input logic [31:0] alu, input logic [31:0] pc);
        int unsigned a = alu & 32'd3;
        logic [31:0] b = (rd >> (8 * a)) & 32'hFF;
        logic [31:0] h = (rd >> (16 * (a / 2))) & 32'hFFFF;
        case (ins[31:26])
            6'h23: return rd;
            6'h21: return h - ((h & 32'h8000) << 1);
            6'h25: return h;
            6'h20: return b - ((b & 32'h80) << 1);
            6'h24: return b;
            6'h03: return pc + 32'd8;
            6'h00: return (ins[5:0] == 6'h09) ? pc + 32'd8 : alu;
            default: return alu;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] addr, input logic [31:0] wbv);
        if (addr == 0) return 32'h0;
        if (!reset && W_TargetReg != 0 && addr == W_TargetReg) return wbv;
        return m_regs[addr];
    endfunction

    task automatic drive(input logic rst, input logic [31:0] ins, input logic [31:0] rd,
                         input logic [31:0] alu, input logic [4:0] tgt, input logic [31:0] pc,
                         input logic [4:0] rs, input logic [4:0] rt);
        reset = rst; W_Ins = ins; W_ReadData = rd; W_ALUData = alu;
        W_TargetReg = tgt; W_PCAddr = pc; rs_addr = rs; rt_addr = rt;
    endtask

    // Check the combinational outputs, clock once, update the model, check instret.
    task automatic cycle();
        logic [31:0] exp_wb;
        #2;
        exp_wb = model_wb(W_Ins, W_ReadData, W_ALUData, W_PCAddr);
        check("wb_data", wb_data, exp_wb);
        check("wb_reg", {27'h0, wb_reg}, (!reset && W_TargetReg != 0) ? {27'h0, W_TargetReg} : 32'h0);
        check("rs_data", rs_data, model_read(rs_addr, exp_wb));
        check("rt_data", rt_data, model_read(rt_addr, exp_wb));
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_instret = 32'h0;
        end else begin
            if (W_TargetReg != 0) m_regs[W_TargetReg] = exp_wb;
            if (W_Ins != 0) m_instret = m_instret + 32'd1;
        end
        #1;
        check("instret", instret, m_instret);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_instret = 32'h0;
        drive(1'b1, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(posedge clk); #1;
        drive(1'b1, 32'h1, 32'h0, 32'h55, 5'd3, 32'h0, 5'd3, 5'd9);
        cycle();
        check("reset_instret", instret, 32'h0);

        // Bypass then storage.
        drive(1'b0, 32'h1, 32'h0, 32'h1234, 5'd5, 32'h100, 5'd5, 5'd5);
        #2; check("bypass_rs", rs_data, 32'h1234);
        cycle();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h104, 5'd5, 5'd0);
        #2; check("stored_rs", rs_data, 32'h1234);
        check("instret_one", instret, 32'h1);
        cycle();

        // Load extensions.
        drive(1'b0, 32'h80000000, 32'h80FF7F01, 32'h2, 5'd8, 32'h0, 5'd8, 5'd0);
        #2; check("lb_a2", wb_data, 32'hFFFFFFFF); cycle();
        drive(1'b0, 32'h90000000, 32'h80FF7F01, 32'h2, 5'd9, 32'h0, 5'd8, 5'd9);
        #2; check("lbu_a2", wb_data, 32'h000000FF); cycle();
        drive(1'b0, 32'h84000000, 32'h80FF7F01, 32'h2, 5'd10, 32'h0, 5'd10, 5'd9);
        #2; check("lh_a2", wb_data, 32'hFFFF80FF); cycle();
        drive(1'b0, 32'h94000000, 32'h80FF7F01, 32'h0, 5'd11, 32'h0, 5'd11, 5'd10);
        #2; check("lhu_a0", wb_data, 32'h00007F01); cycle();
        drive(1'b0, 32'h8C000000, 32'h80FF7F01, 32'h3, 5'd12, 32'h0, 5'd12, 5'd11);
        #2; check("lw_a3", wb_data, 32'h80FF7F01); cycle();

        // Links.
        drive(1'b0, 32'h0C000000, 32'h0, 32'h0, 5'd31, 32'h00003000, 5'd0, 5'd0);
        cycle();
        drive(1'b0, 32'h00000009, 32'h0, 32'h0, 5'd30, 32'hFFFFFFFC, 5'd31, 5'd30);
        #2; check("jal_stored", rs_data, 32'h00003008);
        check("jalr_wrap", wb_data, 32'h00000004); cycle();

        // No-write destination.
        drive(1'b0, 32'h12345678, 32'h0, 32'hDEADBEEF, 5'd0, 32'h0, 5'd0, 5'd5);
        #2; check("rs_zero", rs_data, 32'h0);
        check("wb_reg_zero", {27'h0, wb_reg}, 32'h0); cycle();

        // Reset beats a simultaneous write.
        drive(1'b0, 32'h1, 32'h0, 32'hAA, 5'd7, 32'h0, 5'd7, 5'd0); cycle();
        drive(1'b1, 32'h1, 32'h0, 32'hBB, 5'd7, 32'h0, 5'd7, 5'd0); cycle();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd5);
        #2; check("reset_clears_r7", rs_data, 32'h0);
        check("reset_clears_instret", instret, 32'h0); cycle();

        // Counter wrap, holding on bubbles.
        @(negedge clk);
        force dut.instret_q = 32'hFFFFFFFE;
        #1;
        release dut.instret_q;
        m_instret = 32'hFFFFFFFE;
        @(posedge clk); #1;
        drive(1'b0, 32'hFFFFFFFF, 32'h0, 32'h1, 5'd0, 32'h0, 5'd0, 5'd0); cycle();
        drive(1'b0, 32'h0, 32'h0, 32'h1, 5'd0, 32'h0, 5'd0, 5'd0); cycle();
        check("instret_hold", instret, 32'hFFFFFFFF);
        drive(1'b0, 32'hFFFFFFFF, 32'h0, 32'h1, 5'd0, 32'h0, 5'd0, 5'd0); cycle();
        check("instret_wrap", instret, 32'h0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ins;
            logic [31:0] r;
            logic [4:0]  tgt;
            r = $urandom;
            case ($urandom_range(0, 7))
                0: ins = {6'h23, r[25:0]};
                1: ins = {6'h21, r[25:0]};
                2: ins = {6'h25, r[25:0]};
                3: ins = {6'h20, r[25:0]};
                4: ins = {6'h24, r[25:0]};
                5: ins = {6'h03, r[25:0]};
                6: ins = {6'h00, r[25:6], 6'h09};
                default: ins = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
            endcase
            tgt = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            drive(($urandom_range(0, 39) == 0), ins, $urandom, $urandom, tgt, $urandom,
                  ($urandom_range(0, 3) == 0) ? tgt : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? tgt : 5'($urandom_range(0, 31)));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
